// File: rtl/playback_speed_ctrl.sv
// playback_speed_ctrl: cleans up the three raw speed buttons into single-cycle
// speed up/down/reset events for the sample-clock divider, with auto-repeat on
// up/down, fixed-priority arbitration and clamping, and keeps a registered
// shadow of the divider's half-period count.
module playback_speed_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000,
    parameter int unsigned DIV_DEFAULT     = 1216,
    parameter int unsigned DIV_STEP        = 100,
    parameter int unsigned DIV_MIN         = 216,
    parameter int unsigned DIV_MAX         = 4216
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  key_n,
    output logic        speed_up_event,
    output logic        speed_down_event,
    output logic        speed_reset_event,
    output logic [31:0] divisor,
    output logic        at_min,
    output logic        at_max
);

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESSED,
        S_REPEAT
    } key_state_t;

    localparam logic [31:0] L_DB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] L_DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] L_PERIOD_LAST = 32'(REPEAT_PERIOD - 1);
    localparam logic [31:0] L_DEFAULT     = 32'(DIV_DEFAULT);
    localparam logic [31:0] L_STEP        = 32'(DIV_STEP);
    localparam logic [31:0] L_UP_LIMIT    = 32'(DIV_MIN + DIV_STEP);
    localparam logic [31:0] L_DOWN_LIMIT  = 32'(DIV_MAX - DIV_STEP);

    // Per-key event requests: [0]=up, [1]=down, [2]=speed reset
    logic [2:0]  w_req;
    logic        w_up_fire;
    logic        w_down_fire;
    logic        w_reset_fire;
    logic [31:0] w_div_nxt;

    for (genvar g = 0; g < 3; g++) begin : g_key
        localparam bit CAN_REPEAT = (g != 2);

        logic        r_sync1;
        logic        r_sync2;
        logic        r_stable;
        logic        r_armed;
        logic [31:0] r_db_cnt;
        logic [31:0] r_hold_cnt;
        logic [31:0] w_hold_nxt;
        key_state_t  r_state;
        key_state_t  w_state_nxt;
        logic        w_req_k;

        // Two-flop synchroniser for the asynchronous, active-low button
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= key_n[g];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce; after reset the key must first be seen released for a full
        // debounce window (armed) so a button held through reset cannot fire
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_stable <= 1'b1;
                r_armed  <= 1'b0;
                r_db_cnt <= '0;
            end else if (!r_armed) begin
                if (!r_sync2) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == L_DB_LAST) begin
                    r_armed  <= 1'b1;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 32'd1;
                end
            end else if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == L_DB_LAST) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 32'd1;
            end
        end

        // Key FSM state and hold counter registers
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state    <= S_RELEASED;
                r_hold_cnt <= '0;
            end else begin
                r_state    <= w_state_nxt;
                r_hold_cnt <= w_hold_nxt;
            end
        end

        // Key FSM: request on accepted press, then delayed periodic auto-repeat
        always_comb begin
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold_cnt;
            w_req_k     = 1'b0;
            unique case (r_state)
                S_RELEASED: begin
                    w_hold_nxt = '0;
                    if (!r_stable) begin
                        w_state_nxt = S_PRESSED;
                        w_req_k     = 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (r_stable) begin
                        w_state_nxt = S_RELEASED;
                        w_hold_nxt  = '0;
                    end else if (CAN_REPEAT) begin
                        if (r_hold_cnt == L_DELAY_LAST) begin
                            w_state_nxt = S_REPEAT;
                            w_hold_nxt  = '0;
                            w_req_k     = 1'b1;
                        end else begin
                            w_hold_nxt = r_hold_cnt + 32'd1;
                        end
                    end
                end
                S_REPEAT: begin
                    if (r_stable) begin
                        w_state_nxt = S_RELEASED;
                        w_hold_nxt  = '0;
                    end else if (r_hold_cnt == L_PERIOD_LAST) begin
                        w_hold_nxt = '0;
                        w_req_k    = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 32'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_RELEASED;
                    w_hold_nxt  = '0;
                end
            endcase
        end

        assign w_req[g] = w_req_k;
    end

    // Arbitration reset > up > down, then clamp; a losing request is dropped
    always_comb begin
        w_up_fire    = 1'b0;
        w_down_fire  = 1'b0;
        w_reset_fire = 1'b0;
        w_div_nxt    = divisor;
        if (w_req[2]) begin
            w_reset_fire = 1'b1;
            w_div_nxt    = L_DEFAULT;
        end else if (w_req[0]) begin
            if (divisor >= L_UP_LIMIT) begin
                w_up_fire = 1'b1;
                w_div_nxt = divisor - L_STEP;
            end
        end else if (w_req[1]) begin
            if (divisor <= L_DOWN_LIMIT) begin
                w_down_fire = 1'b1;
                w_div_nxt   = divisor + L_STEP;
            end
        end
    end

    // Registered event pulses, divisor shadow and limit flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_up_event    <= 1'b0;
            speed_down_event  <= 1'b0;
            speed_reset_event <= 1'b0;
            divisor           <= L_DEFAULT;
            at_min            <= 1'b0;
            at_max            <= 1'b0;
        end else begin
            speed_up_event    <= w_up_fire;
            speed_down_event  <= w_down_fire;
            speed_reset_event <= w_reset_fire;
            divisor           <= w_div_nxt;
            at_min            <= (w_div_nxt < L_UP_LIMIT);
            at_max            <= (w_div_nxt > L_DOWN_LIMIT);
        end
    end

endmodule

// File: tb/tb_playback_speed_ctrl.sv
// Directed testbench for playback_speed_ctrl with short debounce/repeat timing.
module tb_playback_speed_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  key_n;
    logic        speed_up_event;
    logic        speed_down_event;
    logic        speed_reset_event;
    logic [31:0] divisor;
    logic        at_min;
    logic        at_max;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;
    int up_q[$];
    int dn_q[$];
    int rs_q[$];

    playback_speed_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .key_n            (key_n),
        .speed_up_event   (speed_up_event),
        .speed_down_event (speed_down_event),
        .speed_reset_event(speed_reset_event),
        .divisor          (divisor),
        .at_min           (at_min),
        .at_max           (at_max)
    );

    always #5 clk = ~clk;

    // Advance n edges, sampling 1 time unit after each and logging pulses by edge number
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_no++;
            #1;
            if (speed_up_event)    up_q.push_back(edge_no);
            if (speed_down_event)  dn_q.push_back(edge_no);
            if (speed_reset_event) rs_q.push_back(edge_no);
        end
    endtask

    task automatic clear_log();
        up_q.delete();
        dn_q.delete();
        rs_q.delete();
    endtask

    // Reset with keys released; edge numbering restarts at the first edge after release
    task automatic do_reset();
        reset = 1'b1;
        key_n = 3'b111;
        tick(2);
        reset   = 1'b0;
        edge_no = 0;
        clear_log();
    endtask

    task automatic press(input logic [2:0] mask);
        key_n = ~mask;
        tick(8);
        key_n = 3'b111;
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_n = 3'b111;
        tick(2);
        checks++;
        if ({speed_up_event, speed_down_event, speed_reset_event} !== 3'b000) begin
            failures++;
            $display("FAIL reset_events got=%b exp=000", {speed_up_event, speed_down_event, speed_reset_event});
        end
        checks++;
        if (divisor !== 32'd1216) begin
            failures++;
            $display("FAIL reset_divisor got=%0d exp=1216", divisor);
        end
        checks++;
        if (at_min !== 1'b0 || at_max !== 1'b0) begin
            failures++;
            $display("FAIL reset_limits got=%b%b exp=00", at_min, at_max);
        end
    endtask

    task automatic test_single_up();
        do_reset();
        tick(9);
        key_n = 3'b110;
        tick(5);
        key_n = 3'b111;
        tick(15);
        checks++;
        if (up_q.size() != 1 || up_q[0] != 16) begin
            failures++;
            $display("FAIL single_up_timing got_n=%0d got_edge=%0d exp_n=1 exp_edge=16",
                     up_q.size(), (up_q.size() > 0) ? up_q[0] : -1);
        end
        checks++;
        if (divisor !== 32'd1116) begin
            failures++;
            $display("FAIL single_up_divisor got=%0d exp=1116", divisor);
        end
        checks++;
        if (dn_q.size() != 0 || rs_q.size() != 0) begin
            failures++;
            $display("FAIL single_up_other got_dn=%0d got_rs=%0d exp=0", dn_q.size(), rs_q.size());
        end
    endtask

    task automatic test_bounce_down();
        int s;
        do_reset();
        tick(6);
        for (int i = 0; i < 3; i++) begin
            key_n = 3'b101;
            tick(1);
            key_n = 3'b111;
            tick(1);
        end
        s     = edge_no + 1;
        key_n = 3'b101;
        tick(10);
        checks++;
        if (dn_q.size() != 1 || dn_q[0] != s + 6) begin
            failures++;
            $display("FAIL bounce_down_event got_n=%0d got_edge=%0d exp_n=1 exp_edge=%0d",
                     dn_q.size(), (dn_q.size() > 0) ? dn_q[0] : -1, s + 6);
        end
        key_n = 3'b111;
        tick(15);
        checks++;
        if (dn_q.size() != 1) begin
            failures++;
            $display("FAIL bounce_down_release got_n=%0d exp_n=1", dn_q.size());
        end
        checks++;
        if (divisor !== 32'd1316) begin
            failures++;
            $display("FAIL bounce_down_divisor got=%0d exp=1316", divisor);
        end
        checks++;
        if (up_q.size() != 0 || rs_q.size() != 0) begin
            failures++;
            $display("FAIL bounce_down_other got_up=%0d got_rs=%0d exp=0", up_q.size(), rs_q.size());
        end
    endtask

    task automatic test_repeat();
        int n0;
        int offs[6] = '{0, 20, 28, 36, 44, 52};
        do_reset();
        tick(6);
        n0    = edge_no + 1;
        key_n = 3'b110;
        tick(60);
        key_n = 3'b111;
        tick(20);
        checks++;
        if (up_q.size() != 6) begin
            failures++;
            $display("FAIL repeat_count got=%0d exp=6", up_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < up_q.size()) begin
                checks++;
                if (up_q[i] != n0 + 6 + offs[i]) begin
                    failures++;
                    $display("FAIL repeat_edge%0d got=%0d exp=%0d", i, up_q[i], n0 + 6 + offs[i]);
                end
            end
        end
        checks++;
        if (divisor !== 32'd616) begin
            failures++;
            $display("FAIL repeat_divisor got=%0d exp=616", divisor);
        end
    endtask

    task automatic test_min_clamp();
        do_reset();
        tick(6);
        for (int i = 1; i <= 10; i++) begin
            press(3'b001);
            if (i == 9) begin
                checks++;
                if (divisor !== 32'd316 || at_min !== 1'b0) begin
                    failures++;
                    $display("FAIL min_step9 got_div=%0d got_min=%b exp_div=316 exp_min=0", divisor, at_min);
                end
            end
        end
        checks++;
        if (up_q.size() != 10 || divisor !== 32'd216 || at_min !== 1'b1) begin
            failures++;
            $display("FAIL min_reach got_n=%0d got_div=%0d got_min=%b exp_n=10 exp_div=216 exp_min=1",
                     up_q.size(), divisor, at_min);
        end
        press(3'b001);
        checks++;
        if (up_q.size() != 10 || divisor !== 32'd216) begin
            failures++;
            $display("FAIL min_suppress got_n=%0d got_div=%0d exp_n=10 exp_div=216", up_q.size(), divisor);
        end
        press(3'b100);
        checks++;
        if (rs_q.size() != 1 || divisor !== 32'd1216 || at_min !== 1'b0) begin
            failures++;
            $display("FAIL min_speed_reset got_n=%0d got_div=%0d got_min=%b exp_n=1 exp_div=1216 exp_min=0",
                     rs_q.size(), divisor, at_min);
        end
    endtask

    task automatic test_max_clamp();
        do_reset();
        tick(6);
        for (int i = 1; i <= 30; i++) begin
            press(3'b010);
            if (i == 29) begin
                checks++;
                if (divisor !== 32'd4116 || at_max !== 1'b0) begin
                    failures++;
                    $display("FAIL max_step29 got_div=%0d got_max=%b exp_div=4116 exp_max=0", divisor, at_max);
                end
            end
        end
        checks++;
        if (dn_q.size() != 30 || divisor !== 32'd4216 || at_max !== 1'b1) begin
            failures++;
            $display("FAIL max_reach got_n=%0d got_div=%0d got_max=%b exp_n=30 exp_div=4216 exp_max=1",
                     dn_q.size(), divisor, at_max);
        end
        press(3'b010);
        checks++;
        if (dn_q.size() != 30 || divisor !== 32'd4216) begin
            failures++;
            $display("FAIL max_suppress got_n=%0d got_div=%0d exp_n=30 exp_div=4216", dn_q.size(), divisor);
        end
    endtask

    task automatic test_arbitration_and_midhold_reset();
        int s;
        do_reset();
        tick(6);
        press(3'b011);
        checks++;
        if (up_q.size() != 1 || dn_q.size() != 0 || divisor !== 32'd1116) begin
            failures++;
            $display("FAIL updown_together got_up=%0d got_dn=%0d got_div=%0d exp_up=1 exp_dn=0 exp_div=1116",
                     up_q.size(), dn_q.size(), divisor);
        end
        clear_log();
        s     = edge_no + 1;
        key_n = 3'b000;
        tick(7);
        checks++;
        if (rs_q.size() != 1 || rs_q[0] != s + 6) begin
            failures++;
            $display("FAIL all_keys_reset got_n=%0d got_edge=%0d exp_n=1 exp_edge=%0d",
                     rs_q.size(), (rs_q.size() > 0) ? rs_q[0] : -1, s + 6);
        end
        checks++;
        if (up_q.size() != 0 || dn_q.size() != 0 || divisor !== 32'd1216) begin
            failures++;
            $display("FAIL all_keys_other got_up=%0d got_dn=%0d got_div=%0d exp_up=0 exp_dn=0 exp_div=1216",
                     up_q.size(), dn_q.size(), divisor);
        end
        checks++;
        if (speed_reset_event !== 1'b1) begin
            failures++;
            $display("FAIL all_keys_pulse_now got=%b exp=1", speed_reset_event);
        end
        reset = 1'b1;
        #2;
        checks++;
        if ({speed_up_event, speed_down_event, speed_reset_event} !== 3'b000
            || divisor !== 32'd1216 || at_min !== 1'b0 || at_max !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got_ev=%b got_div=%0d got_lim=%b%b exp_ev=000 exp_div=1216 exp_lim=00",
                     {speed_up_event, speed_down_event, speed_reset_event}, divisor, at_min, at_max);
        end
        tick(3);
        reset = 1'b0;
        clear_log();
        tick(60);
        checks++;
        if (up_q.size() != 0 || dn_q.size() != 0 || rs_q.size() != 0) begin
            failures++;
            $display("FAIL held_after_reset got_up=%0d got_dn=%0d got_rs=%0d exp=0",
                     up_q.size(), dn_q.size(), rs_q.size());
        end
        key_n = 3'b111;
        tick(15);
        checks++;
        if (up_q.size() != 0 || dn_q.size() != 0 || rs_q.size() != 0) begin
            failures++;
            $display("FAIL release_after_reset got_up=%0d got_dn=%0d got_rs=%0d exp=0",
                     up_q.size(), dn_q.size(), rs_q.size());
        end
        press(3'b001);
        checks++;
        if (up_q.size() != 1 || divisor !== 32'd1116) begin
            failures++;
            $display("FAIL new_press_after_reset got_n=%0d got_div=%0d exp_n=1 exp_div=1116",
                     up_q.size(), divisor);
        end
    endtask

    initial begin
        reset = 1'b1;
        key_n = 3'b111;
        test_reset();
        test_single_up();
        test_bounce_down();
        test_repeat();
        test_min_clamp();
        test_max_clamp();
        test_arbitration_and_midhold_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
